// File: rtl/instr_fetch_unit_pkg.sv
// Shared RV32I definitions for the fetch unit: opcodes, the canonical NOP,
// fetch FSM state encoding and the PC-alignment helper.
package instr_fetch_unit_pkg;

  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LTYPE  = 7'b0000011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STYPE  = 7'b0100011;
  localparam logic [6:0] OP_SBTYPE = 7'b1100011;
  localparam logic [6:0] OP_UTYPE  = 7'b0110111;
  localparam logic [6:0] OP_UJTYPE = 7'b1101111;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_perf_cnt.sv
// Fetch/flush event counters for the fetch unit; only instantiated when
// IFU_PERF_EN is defined. Both counters wrap at 2^32.
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        flush_inc_i,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_flushed_o
);

  logic [31:0] fetched_q, flushed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (fetch_inc_i) fetched_q <= fetched_q + 32'd1;
      if (flush_inc_i) flushed_q <= flushed_q + 32'd1;
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_flushed_o = flushed_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect/squash support.
// Optional IFU_PERF_EN adds perf_fetched/perf_flushed event counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        mis_q, mis_d;
  logic [31:0] target;
  logic        gnt_acc;
  logic        fetch_evt, flush_evt;

  assign target  = word_align(redirect_pc);
  // req_q is 0 for the first cycle out of reset, so a stray gnt there is not a handshake
  assign gnt_acc = (state_q == S_REQ) && req_q && imem_gnt;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    mis_d     = redirect && (redirect_pc[1:0] != 2'b00);
    fetch_evt = 1'b0;
    flush_evt = 1'b0;
    case (state_q)
      S_REQ: begin
        if (gnt_acc) state_d = S_WAIT;
        if (redirect) begin
          pc_d = target;
          if (gnt_acc) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = target;
          if (imem_rvalid) begin
            kill_d    = 1'b0;
            state_d   = S_REQ;
            flush_evt = 1'b1;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d    = 1'b0;
            state_d   = S_REQ;
            flush_evt = 1'b1;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        fetch_evt = instr_ready;
        if (redirect) begin
          valid_d   = 1'b0;
          instr_d   = NOP_INSTR;
          pc_d      = target;
          state_d   = S_REQ;
          flush_evt = 1'b1;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign instr_pc     = ipc_q;
  assign misalign_err = mis_q;

`ifdef IFU_PERF_EN
  ifu_perf_cnt u_perf (
    .clk            (clk),
    .rst            (reset),
    .fetch_inc_i    (fetch_evt),
    .flush_inc_i    (flush_evt),
    .perf_fetched_o (perf_fetched),
    .perf_flushed_o (perf_flushed)
  );
`else
  logic unused_evt;
  assign unused_evt = fetch_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: zero-wait fetch, decode stall,
// redirects in each FSM state, and reset mid-fetch.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err)
`ifdef IFU_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request at exp_addr granted immediately, data back the next cycle; leaves DUT in S_HOLD.
  task automatic fetch_cycle(input logic [31:0] exp_addr, input logic [31:0] data);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL fetch_req: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, exp_addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait: req=%b valid=%b, want 0 0", imem_req, instr_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== data || instr_pc !== exp_addr) begin
      errors++;
      $display("FAIL fetch_data: valid=%b instr=%h pc=%h, want 1 %h %h",
               instr_valid, instr, instr_pc, data, exp_addr);
    end
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) step();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr !== NOP || instr_pc !== 32'h0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: req=%b addr=%h valid=%b instr=%h pc=%h mis=%b, want 0 0 0 %h 0 0",
               imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err, NOP);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_zero_wait();
    int vcnt = 0;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i) * 32'd4;
      fetch_cycle(a, 32'h0000_0093 | (32'(i) << 20));
      instr_ready = 1'b1;
      // valid high in exactly one of the three cycles of the period
      vcnt = 0;
      for (int c = 0; c < 3; c++) begin
        if (instr_valid === 1'b1) vcnt++;
        if (c < 2) step();
      end
      instr_ready = 1'b0;
      checks++;
      if (vcnt != 1) begin
        errors++;
        $display("FAIL zero_wait_rate: valid cycles=%0d want 1", vcnt);
      end
      step();
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL zero_wait_next: req=%b addr=%h, want 1 0000000c", imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    fetch_cycle(32'hC, 32'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'hC ||
          imem_req !== 1'b0 || imem_addr !== 32'hC) begin
        errors++;
        $display("FAIL stall_hold: valid=%b instr=%h pc=%h req=%b addr=%h",
                 instr_valid, instr, instr_pc, imem_req, imem_addr);
      end
    end
    consume();
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_release: valid=%b instr=%h req=%b addr=%h, want 0 %h 1 00000010",
               instr_valid, instr, imem_req, imem_addr, NOP);
    end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    redirect = 1'b0; imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait: valid=%b req=%b addr=%h mis=%b, want 0 1 00000100 0",
               instr_valid, imem_req, imem_addr, misalign_err);
    end
    fetch_cycle(32'h100, 32'h0010_0113);
    consume();
  endtask

  task automatic test_redirect_req_gnt();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL redir_gnt_pre: req=%b addr=%h, want 1 00000104", imem_req, imem_addr);
    end
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    imem_gnt = 1'b0; redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_gnt_drop: valid=%b req=%b addr=%h, want 0 1 00000200",
               instr_valid, imem_req, imem_addr);
    end
    fetch_cycle(32'h200, 32'h0020_0193);
  endtask

  task automatic test_redirect_hold();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h302;
    step();
    instr_ready = 1'b0; redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOP || misalign_err !== 1'b1 ||
        imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL redir_hold: valid=%b instr=%h mis=%b req=%b addr=%h, want 0 %h 1 1 00000300",
               instr_valid, instr, misalign_err, imem_req, imem_addr, NOP);
    end
    step();
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: mis=%b want 0", misalign_err);
    end
`ifdef IFU_PERF_EN
    checks++;
    if (perf_fetched !== 32'd6 || perf_flushed !== 32'd3) begin
      errors++;
      $display("FAIL perf_counts: fetched=%0d flushed=%0d, want 6 3", perf_fetched, perf_flushed);
    end
`endif
  endtask

  task automatic test_redirect_req_nognt();
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL redir_nognt: req=%b addr=%h mis=%b, want 1 00000040 0",
               imem_req, imem_addr, misalign_err);
    end
  endtask

  task automatic test_reset_midfetch();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr !== NOP || instr_pc !== 32'h0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: req=%b addr=%h valid=%b instr=%h pc=%h mis=%b",
               imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err);
    end
    step();
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_stray: valid=%b req=%b addr=%h, want 0 1 00000000",
               instr_valid, imem_req, imem_addr);
    end
`ifdef IFU_PERF_EN
    checks++;
    if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: fetched=%0d flushed=%0d, want 0 0", perf_fetched, perf_flushed);
    end
`endif
    fetch_cycle(32'h0, 32'h0030_0213);
    consume();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_req_gnt();
    test_redirect_hold();
    test_redirect_req_nognt();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
